// File: rtl/wave_dispatcher.sv
// wave_dispatcher: accepts one thread block at a time and splits it into waves of
// WAVE_SIZE threads. Waves are issued at most one per cycle to free SIMD units, and
// block_done pulses once every issued wave has reported completion.
// Optional feature: define WAVE_DISPATCH_RR_EN to pick free SIMDs round-robin.
// Without it, the lowest-index free SIMD always wins.
module wave_dispatcher #(
    parameter int NUM_SIMD  = 4,
    parameter int WAVE_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                block_valid,
    output logic                block_ready,
    input  logic signed [31:0]  block_id_in,
    input  logic [31:0]         block_dim,
    output logic [NUM_SIMD-1:0] simd_start,
    input  logic [NUM_SIMD-1:0] simd_done,
    output logic signed [31:0]  block_id,
    output logic signed [31:0]  wave_id,
    output logic [31:0]         num_waves_in_block,
    output logic                block_done
);
    localparam int          SHIFT    = $clog2(WAVE_SIZE);
    localparam int          IDX_W    = (NUM_SIMD > 1) ? $clog2(NUM_SIMD) : 1;
    localparam logic [31:0] LOW_MASK = 32'(WAVE_SIZE - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [NUM_SIMD-1:0] start_q, start_d;
    logic [NUM_SIMD-1:0] busy_q, busy_d;
    logic signed [31:0]  block_id_q, block_id_d;
    logic signed [31:0]  wave_id_q, wave_id_d;
    logic [31:0]         num_waves_q, num_waves_d;
    logic [31:0]         issued_q, issued_d;
    logic [31:0]         done_cnt_q, done_cnt_d;

    logic [31:0]         dim_waves;
    logic [31:0]         done_hits;
    logic                accept;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;

    // Ceiling division by shifting, so block_dim near 2^32 cannot overflow.
    assign dim_waves = (block_dim >> SHIFT) + {31'd0, |(block_dim & LOW_MASK)};
    // ready_q is only ever high in IDLE.
    assign accept    = block_valid && ready_q;

`ifdef WAVE_DISPATCH_RR_EN
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] rot_idx [NUM_SIMD];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SIMD; gi++) begin : g_rot
            assign rot_idx[gi] = IDX_W'((32'(rr_q) + 32'(gi)) % 32'(NUM_SIMD));
        end
    endgenerate

    // The pointer moves to the slot after the one just issued, wrapping at the top.
    assign rr_d = (free_idx == IDX_W'(NUM_SIMD - 1)) ? '0 : free_idx + IDX_W'(1);

    // Find the first free slot, searching upward from the round-robin pointer.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = NUM_SIMD - 1; k >= 0; k--) begin
            if (!busy_q[rot_idx[k]]) begin
                free_found = 1'b1;
                free_idx   = rot_idx[k];
            end
        end
    end

    // Round-robin pointer register; it only advances when a wave is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else if (|start_d) begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: the lowest-index free slot wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = NUM_SIMD - 1; k >= 0; k--) begin
            if (!busy_q[k]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // Count completions; a done pulse on an idle SIMD is not counted.
    always_comb begin
        done_hits = '0;
        for (int i = 0; i < NUM_SIMD; i++) begin
            done_hits = done_hits + 32'(busy_q[i] & simd_done[i]);
        end
    end

    // Next-state logic. Wave 0 is issued on the accept edge itself.
    always_comb begin
        state_d     = state_q;
        start_d     = '0;
        busy_d      = busy_q & ~simd_done;
        block_id_d  = block_id_q;
        wave_id_d   = wave_id_q;
        num_waves_d = num_waves_q;
        issued_d    = issued_q;
        done_cnt_d  = done_cnt_q + done_hits;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    block_id_d  = block_id_in;
                    num_waves_d = dim_waves;
                    wave_id_d   = '0;
                    issued_d    = '0;
                    done_cnt_d  = '0;
                    if (dim_waves == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DISPATCH;
                        if (free_found) begin
                            start_d[free_idx] = 1'b1;
                            busy_d[free_idx]  = 1'b1;
                            issued_d          = 32'd1;
                            // A single-wave block has nothing left to dispatch.
                            if (dim_waves == 32'd1) begin
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            DISPATCH: begin
                if (free_found) begin
                    start_d[free_idx] = 1'b1;
                    busy_d[free_idx]  = 1'b1;
                    wave_id_d         = $signed(issued_q);
                    issued_d          = issued_q + 32'd1;
                    if (issued_q == num_waves_q - 32'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done_cnt_d == num_waves_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Hold ready low while in reset, so it rises one cycle after reset is released.
    assign ready_d = (state_d == IDLE);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            start_q     <= '0;
            busy_q      <= '0;
            block_id_q  <= '0;
            wave_id_q   <= '0;
            num_waves_q <= '0;
            issued_q    <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            block_id_q  <= block_id_d;
            wave_id_q   <= wave_id_d;
            num_waves_q <= num_waves_d;
            issued_q    <= issued_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign block_ready        = ready_q;
    assign simd_start         = start_q;
    assign block_id           = block_id_q;
    assign wave_id            = wave_id_q;
    assign num_waves_in_block = num_waves_q;
    assign block_done         = (state_q == DONE);

endmodule

// File: tb/tb_wave_dispatcher.sv
// Testbench for wave_dispatcher. It uses a per-cycle reference model, a table of
// block sizes, hand-written corner sequences and a randomized run.
module tb_wave_dispatcher;
    localparam int NS = 4;
    localparam int WS = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               block_valid;
    logic               block_ready;
    logic signed [31:0] block_id_in;
    logic [31:0]        block_dim;
    logic [NS-1:0]      simd_start;
    logic [NS-1:0]      simd_done;
    logic signed [31:0] block_id;
    logic signed [31:0] wave_id;
    logic [31:0]        num_waves_in_block;
    logic               block_done;

    int nvec = 0;
    int nerr = 0;

    wave_dispatcher #(.NUM_SIMD(NS), .WAVE_SIZE(WS)) dut (
        .clk                (clk),
        .rst                (rst),
        .block_valid        (block_valid),
        .block_ready        (block_ready),
        .block_id_in        (block_id_in),
        .block_dim          (block_dim),
        .simd_start         (simd_start),
        .simd_done          (simd_done),
        .block_id           (block_id),
        .wave_id            (wave_id),
        .num_waves_in_block (num_waves_in_block),
        .block_done         (block_done)
    );

    always #5 clk = ~clk;

    // Reference model: the expected outputs for the current cycle, plus block bookkeeping.
    bit            m_busy [NS];
    bit            m_active;
    int            m_to_issue;
    int            m_remaining;
    int            m_next_wave;
    int            m_rr;
    logic          exp_ready;
    logic          exp_done;
    logic [NS-1:0] exp_start;
    logic [31:0]   exp_bid;
    logic [31:0]   exp_wave;
    logic [31:0]   exp_nw;

    function automatic int pick_free();
`ifdef WAVE_DISPATCH_RR_EN
        for (int k = 0; k < NS; k++) begin
            if (!m_busy[(m_rr + k) % NS]) return (m_rr + k) % NS;
        end
`else
        for (int k = 0; k < NS; k++) begin
            if (!m_busy[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [31:0] d,
                              input logic [31:0] id, input logic [NS-1:0] dn);
        int               slot;
        logic [NS-1:0]    nstart;
        bit               ndone;
        longint unsigned  w;
        if (r) begin
            for (int i = 0; i < NS; i++) m_busy[i] = 1'b0;
            m_active = 1'b0; m_to_issue = 0; m_remaining = 0; m_next_wave = 0; m_rr = 0;
            exp_ready = 1'b0; exp_done = 1'b0; exp_start = '0;
            exp_bid = '0; exp_wave = '0; exp_nw = '0;
            return;
        end
        nstart = '0;
        ndone  = 1'b0;
        slot   = pick_free();   // eligibility uses busy as it stood before this edge
        for (int i = 0; i < NS; i++) begin
            if (m_busy[i] && dn[i]) begin
                m_busy[i]   = 1'b0;
                m_remaining = m_remaining - 1;
            end
        end
        if (exp_done) begin
            m_active = 1'b0;
        end else if (exp_ready && v) begin
            w        = (64'(d) + 64'(WS - 1)) / 64'(WS);
            exp_bid  = id;
            exp_nw   = 32'(w);
            exp_wave = '0;
            if (w == 0) begin
                ndone = 1'b1;
            end else begin
                nstart[slot]   = 1'b1;
                m_busy[slot]   = 1'b1;
                m_rr           = (slot + 1) % NS;
                m_next_wave    = 1;
                m_to_issue     = int'(w) - 1;
                m_remaining    = int'(w);
                m_active       = 1'b1;
            end
        end else if (m_active && m_to_issue > 0) begin
            if (slot >= 0) begin
                nstart[slot] = 1'b1;
                m_busy[slot] = 1'b1;
                m_rr         = (slot + 1) % NS;
                exp_wave     = 32'(m_next_wave);
                m_next_wave  = m_next_wave + 1;
                m_to_issue   = m_to_issue - 1;
            end
        end else if (m_active && m_remaining == 0) begin
            ndone    = 1'b1;
            m_active = 1'b0;
        end
        exp_start = nstart;
        exp_done  = ndone;
        exp_ready = !m_active && !ndone;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec = nvec + 1;
        if (act !== expv) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic compare_all();
        chk("block_ready", 32'(block_ready), 32'(exp_ready));
        chk("simd_start", 32'(simd_start), 32'(exp_start));
        chk("block_done", 32'(block_done), 32'(exp_done));
        chk("block_id", 32'(block_id), exp_bid);
        chk("wave_id", 32'(wave_id), exp_wave);
        chk("num_waves", num_waves_in_block, exp_nw);
    endtask

    // Drive one cycle of inputs, advance the model, then compare on the falling edge.
    task automatic cycle(input bit r, input bit v, input logic [31:0] d,
                         input logic [31:0] id, input logic [NS-1:0] dn);
        rst         = r;
        block_valid = v;
        block_dim   = d;
        block_id_in = id;
        simd_done   = dn;
        model_step(r, v, d, id, dn);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'd0, 32'd0, '0);
    endtask

    task automatic restart();
        cycle(1'b1, 1'b0, 32'd0, 32'd0, '0);
        idle();
    endtask

    typedef struct {
        logic [31:0]   dim;
        logic [31:0]   nw;
        logic [NS-1:0] start;
        logic          done;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        int pulses;
        tbl[0] = '{32'd0,          32'd0,         4'b0000, 1'b1};
        tbl[1] = '{32'd1,          32'd1,         4'b0001, 1'b0};
        tbl[2] = '{32'd31,         32'd1,         4'b0001, 1'b0};
        tbl[3] = '{32'd32,         32'd1,         4'b0001, 1'b0};
        tbl[4] = '{32'd33,         32'd2,         4'b0001, 1'b0};
        tbl[5] = '{32'd100,        32'd4,         4'b0001, 1'b0};
        tbl[6] = '{32'd192,        32'd6,         4'b0001, 1'b0};
        tbl[7] = '{32'hFFFF_FFFF,  32'd134217728, 4'b0001, 1'b0};
        tbl[8] = '{32'hFFFF_FFE0,  32'd134217727, 4'b0001, 1'b0};

        rst = 1'b1; block_valid = 1'b0; block_dim = '0; block_id_in = '0; simd_done = '0;
        @(negedge clk);

        // Reset values, then ready rises one cycle after reset is released.
        cycle(1'b1, 1'b0, 32'd0, 32'd0, '0);
        chk("rst_ready", 32'(block_ready), 32'd0);
        chk("rst_nw", num_waves_in_block, 32'd0);
        idle();
        chk("ready_after_rst", 32'(block_ready), 32'd1);

        // Wave count and first issue for each block size in the table.
        for (int i = 0; i < 9; i++) begin
            restart();
            cycle(1'b0, 1'b1, tbl[i].dim, 32'(i + 100), '0);
            chk("tbl_nw", num_waves_in_block, tbl[i].nw);
            chk("tbl_start", 32'(simd_start), 32'(tbl[i].start));
            chk("tbl_done", 32'(block_done), 32'(tbl[i].done));
        end

        // A 100-thread block gives four waves on SIMD0..3 in consecutive cycles.
        restart();
        cycle(1'b0, 1'b1, 32'd100, 32'd7, '0);
        chk("r31_nw", num_waves_in_block, 32'd4);
        chk("r31_start0", 32'(simd_start), 32'd1);
        chk("r31_wave0", 32'(wave_id), 32'd0);
        for (int j = 1; j < 4; j++) begin
            idle();
            chk("r31_start", 32'(simd_start), 32'd1 << j);
            chk("r31_wave", 32'(wave_id), 32'(j));
        end
        idle();
        chk("r31_no_more", 32'(simd_start), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b1111);
        chk("r31_done", 32'(block_done), 32'd1);
        idle();
        chk("r31_ready", 32'(block_ready), 32'd1);

        // An empty block completes at once, without any start.
        restart();
        cycle(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFB, '0);
        chk("r32_done", 32'(block_done), 32'd1);
        chk("r32_start", 32'(simd_start), 32'd0);
        chk("r32_bid", 32'(block_id), 32'hFFFF_FFFB);
        idle();
        chk("r32_done_low", 32'(block_done), 32'd0);
        chk("r32_ready", 32'(block_ready), 32'd1);

        // A slot freed by a done pulse is issued two cycles after that done cycle.
        restart();
        cycle(1'b0, 1'b1, 32'd192, 32'd3, '0);
        idle(); idle(); idle();
        idle();
        chk("r33_all_busy", 32'(simd_start), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b0100);
        chk("r33_not_yet", 32'(simd_start), 32'd0);
        idle();
        chk("r33_start", 32'(simd_start), 32'b0100);
        chk("r33_wave", 32'(wave_id), 32'd4);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b0001);
        idle();
        chk("r33_start5", 32'(simd_start), 32'b0001);
        chk("r33_wave5", 32'(wave_id), 32'd5);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b1111);
        chk("r33_done", 32'(block_done), 32'd1);

        // Two simultaneous final done pulses, with a stray one before: one block_done.
        restart();
        cycle(1'b0, 1'b1, 32'd128, 32'd11, '0);
        idle(); idle(); idle();
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b0110);
        chk("r34_early", 32'(block_done), 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b0010);
        chk("r34_stray", 32'(block_done), 32'd0);
        pulses = 0;
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b1001);
        pulses = pulses + int'(block_done);
        for (int j = 0; j < 3; j++) begin
            idle();
            pulses = pulses + int'(block_done);
        end
        chk("r34_pulses", 32'(pulses), 32'd1);

        // A reset during DRAIN abandons the block.
        restart();
        cycle(1'b0, 1'b1, 32'd64, 32'd9, '0);
        idle();
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b0001);
        cycle(1'b1, 1'b0, 32'd0, 32'd0, '0);
        chk("r35_ready", 32'(block_ready), 32'd0);
        chk("r35_start", 32'(simd_start), 32'd0);
        chk("r35_done", 32'(block_done), 32'd0);
        chk("r35_bid", 32'(block_id), 32'd0);
        chk("r35_wave", 32'(wave_id), 32'd0);
        chk("r35_nw", num_waves_in_block, 32'd0);
        pulses = 0;
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b0010);
        pulses = pulses + int'(block_done);
        chk("r35_ready_back", 32'(block_ready), 32'd1);
        for (int j = 0; j < 3; j++) begin
            idle();
            pulses = pulses + int'(block_done);
        end
        chk("r35_no_done", 32'(pulses), 32'd0);

`ifdef WAVE_DISPATCH_RR_EN
        // After SIMD1 was the last issued slot, the next wave goes to SIMD2.
        restart();
        cycle(1'b0, 1'b1, 32'd64, 32'd5, '0);
        idle();
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'b0011);
        idle();
        cycle(1'b0, 1'b1, 32'd32, 32'd6, '0);
        chk("r36_rr", 32'(simd_start), 32'b0100);
`endif

        // Randomized traffic, checked every cycle against the model.
        restart();
        for (int c = 0; c < 3000; c++) begin
            bit            r;
            bit            v;
            int            sel;
            logic [31:0]   d;
            logic [NS-1:0] dn;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 1) == 1);
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      d = 32'd0;
            else if (sel < 5) d = $urandom_range(1, 64);
            else              d = $urandom_range(65, 400);
            dn = '0;
            for (int i = 0; i < NS; i++) begin
                if (m_busy[i]) dn[i] = ($urandom_range(0, 3) == 0);
                else           dn[i] = ($urandom_range(0, 15) == 0);
            end
            cycle(r, v, d, $urandom, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wave_dispatcher.md
WAVE_DISPATCHER -- requirements
Module: wave_dispatcher

Interface
REQ-001 SHALL have parameter NUM_SIMD, default 4, number of SIMD units served.
REQ-002 SHALL have parameter WAVE_SIZE, default 32, threads per wave, power of two.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port block_valid, input, 1, a block is offered.
REQ-006 SHALL have port block_ready, output, 1, dispatcher can accept a block.
REQ-007 SHALL have port block_id_in, input, 32 signed, ID of the offered block.
REQ-008 SHALL have port block_dim, input, 32, threads in the offered block.
REQ-009 SHALL have port simd_start, output, NUM_SIMD, one-cycle start pulse per SIMD.
REQ-010 SHALL have port simd_done, input, NUM_SIMD, one-cycle wave-complete pulse per SIMD.
REQ-011 SHALL have port block_id, output, 32 signed, ID of the current block, valid with any simd_start.
REQ-012 SHALL have port wave_id, output, 32 signed, wave index, valid with simd_start.
REQ-013 SHALL have port num_waves_in_block, output, 32, wave count of the current block.
REQ-014 SHALL have port block_done, output, 1, one-cycle pulse when all waves of the block have completed.

Function
REQ-015 SHALL use FSM states IDLE, DISPATCH, DRAIN, DONE.
REQ-016 SHALL drive block_ready=1 only in IDLE; accept on edge with block_valid&&block_ready, latching block_id_in and block_dim.
REQ-017 SHALL compute num_waves_in_block = ceil(block_dim/WAVE_SIZE) at acceptance, no overflow for block_dim up to 2^32-1.
REQ-018 SHALL move IDLE->DISPATCH on accept; if num_waves_in_block=0, move IDLE->DONE instead.
REQ-019 SHALL keep a busy bit per SIMD; set on the edge simd_start is issued, cleared on the edge simd_done is sampled.
REQ-020 SHALL, in DISPATCH, issue at most one wave per cycle to the lowest-index SIMD whose registered busy bit is 0.
REQ-021 SHALL register simd_start and wave_id: first start is visible in the cycle after the accept edge, with wave_id=0; wave_id increments by 1 per issued wave.
REQ-022 SHALL not issue to a SIMD whose simd_done is sampled on the same edge; the slot becomes eligible one cycle later.
REQ-023 SHALL move DISPATCH->DRAIN on the edge the last wave (wave_id=num_waves_in_block-1) is issued.
REQ-024 SHALL move DRAIN->DONE when the completed-wave count equals num_waves_in_block, counting done pulses arriving in any state.
REQ-025 SHALL assert block_done for exactly one cycle in DONE, then return to IDLE.
REQ-026 SHALL ignore simd_done on a SIMD that is not busy, with no count change.
REQ-027 SHALL count simultaneous simd_done pulses on several SIMDs in the same cycle individually.

Reset
REQ-028 SHALL, on rst, clear state to IDLE and set simd_start=0, block_done=0, busy=0, counters=0, wave_id=0, block_id=0, num_waves_in_block=0; block_ready becomes 1 in the cycle after reset deasserts.
REQ-029 SHALL, on rst asserted mid-block, abandon the block with no block_done and no further simd_start.

Configuration
REQ-030 SHALL support macro WAVE_DISPATCH_RR_EN: when defined, pick a free SIMD by round-robin, searching from the slot after the last issued, wrapping at NUM_SIMD-1->0, pointer reset to 0; when undefined, use the fixed lowest-index priority of REQ-020.

Verification
REQ-031 SHALL check: block_dim=100, NUM_SIMD=4, no done -> num_waves_in_block=4, starts on SIMD0..3 in four consecutive cycles, wave_id 0..3, then DRAIN.
REQ-032 SHALL check: block_dim=0 -> no simd_start, block_done one cycle after the accept-edge cycle, then block_ready=1.
REQ-033 SHALL check: block_dim=192 (6 waves), all SIMDs busy, done on SIMD2 -> wave_id=4 issued to SIMD2 two cycles after the done cycle (REQ-022).
REQ-034 SHALL check: simultaneous simd_done on SIMD0 and SIMD3 for the last two waves -> block_done pulses exactly once.
REQ-035 SHALL check: rst asserted during DRAIN -> all outputs at reset values the next cycle, no block_done.
REQ-036 SHALL check, with WAVE_DISPATCH_RR_EN defined: last issue SIMD1, SIMD0 and SIMD2 free -> next issue goes to SIMD2.
